// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its executor: opcodes, operands,
// instruction word layout, 64-bit result and the executor FSM state encoding.
package instr_register_pkg;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 6;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0]  operand_t;
  typedef logic [ADDR_W-1:0]   address_t;
  typedef logic [CNT_W-1:0]    count_t;
  typedef logic signed [63:0]  result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    EXEC = 3'd2,
    DIVW = 3'd3,
    OUT  = 3'd4,
    DONE = 3'd5
  } exec_state_t;

  function automatic logic is_divide(opcode_t opc);
    return (opc == DIV) || (opc == MOD);
  endfunction

endpackage

// File: rtl/instr_exec_unit_if.sv
// Run control, instruction register read port and result stream of the executor.
interface instr_exec_unit_if;
  import instr_register_pkg::*;

  logic         start;
  address_t     start_ptr;
  count_t       count;
  logic         busy;
  logic         done;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         res_valid;
  logic         res_ready;
  result_t      res_data;
  address_t     res_ptr;
  logic         res_err;

  modport master (
    input  start, start_ptr, count, instruction_word, res_ready,
    output busy, done, read_pointer, res_valid, res_data, res_ptr, res_err
  );

  modport slave (
    output start, start_ptr, count, instruction_word, res_ready,
    input  busy, done, read_pointer, res_valid, res_data, res_ptr, res_err
  );

endinterface

// File: rtl/instr_div_iter.sv
// Restoring signed divider, one quotient bit per cycle; the first bit is resolved on the
// start edge so done rises DIV_BITS-1 cycles after start. Synchronous reset aborts a division.
module instr_div_iter
  import instr_register_pkg::*;
#(
  parameter int DIV_BITS = 32
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     start,
  input  operand_t dividend,
  input  operand_t divisor,
  output logic     busy,
  output logic     done,
  output result_t  quotient,
  output result_t  remainder
);

  localparam int CW = $clog2(DIV_BITS + 1);
  typedef logic [DIV_BITS-1:0] mag_t;

  mag_t          rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, q_neg, r_neg;

  mag_t          a_mag, b_mag;
  mag_t          src_rem, src_quo, src_dvs;
  mag_t          step_rem, step_quo;
  logic [DIV_BITS:0] trial;
  logic          borrow;
  result_t       q_ext, r_ext;

  always_comb begin
    a_mag   = mag_t'(dividend[31] ? -dividend : dividend);
    b_mag   = mag_t'(divisor[31] ? -divisor : divisor);
    src_rem = start ? '0 : rem_q;
    src_quo = start ? a_mag : quo_q;
    src_dvs = start ? b_mag : dvs_q;
    // Shifted partial remainder minus divisor; MSB set means the subtraction underflowed.
    trial    = {src_rem, src_quo[DIV_BITS-1]} - {1'b0, src_dvs};
    borrow   = trial[DIV_BITS];
    step_rem = borrow ? {src_rem[DIV_BITS-2:0], src_quo[DIV_BITS-1]} : trial[DIV_BITS-1:0];
    step_quo = {src_quo[DIV_BITS-2:0], ~borrow};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
    end else if (start) begin
      rem_q  <= step_rem;
      quo_q  <= step_quo;
      dvs_q  <= b_mag;
      cnt_q  <= CW'(DIV_BITS - 1);
      busy_q <= 1'b1;
      q_neg  <= dividend[31] ^ divisor[31];
      r_neg  <= dividend[31];
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        rem_q <= step_rem;
        quo_q <= step_quo;
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  always_comb begin
    q_ext     = $signed({{(64-DIV_BITS){1'b0}}, quo_q});
    r_ext     = $signed({{(64-DIV_BITS){1'b0}}, rem_q});
    quotient  = q_neg ? -q_ext : q_ext;
    remainder = r_neg ? -r_ext : r_ext;
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == '0);

endmodule

// File: rtl/instr_exec_unit.sv
// Walks count entries from start_ptr, executes each and streams one result per entry;
// 3 cycles start-to-result (+DIV_BITS for DIV/MOD); res_ready low holds the result and stops reads.
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int DIV_BITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  instr_exec_unit_if.master  bus
);

  exec_state_t  state_q, state_d;
  address_t     ptr_q, res_ptr_q, next_ptr;
  count_t       remaining_q;
  result_t      res_data_q;
  logic         res_err_q, mod_q;

  instruction_t instr;
  result_t      a64, b64, alu_res;
  logic         alu_err;
  logic         div_start, div_busy, div_done;
  result_t      div_quo, div_rem;
  logic         busy_o, done_o, valid_o;

  assign instr    = bus.instruction_word;
  assign next_ptr = address_t'((32'(ptr_q) + 32'd1) % DEPTH);

  always_comb begin
    a64     = result_t'(instr.op_a);
    b64     = result_t'(instr.op_b);
    alu_res = '0;
    alu_err = 1'b0;
    case (instr.opc)
      ZERO:     alu_res = '0;
      PASSA:    alu_res = a64;
      PASSB:    alu_res = b64;
      ADD:      alu_res = a64 + b64;
      SUB:      alu_res = a64 - b64;
      MULT:     alu_res = a64 * b64;
      DIV, MOD: alu_err = (instr.op_b == '0);
      default:  alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = (bus.count == '0) ? DONE : RD;
      RD:   state_d = EXEC;
      EXEC: state_d = (is_divide(instr.opc) && instr.op_b != '0) ? DIVW : OUT;
      DIVW: if (div_done) state_d = OUT;
      OUT:  if (bus.res_ready) state_d = (remaining_q == CNT_W'(1)) ? DONE : RD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_q != IDLE) && (state_q != DONE);
    done_o    = (state_q == DONE);
    valid_o   = (state_q == OUT);
    div_start = (state_q == EXEC) && is_divide(instr.opc) && (instr.op_b != '0) && !div_busy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      remaining_q <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_ptr_q   <= '0;
      mod_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          ptr_q       <= bus.start_ptr;
          remaining_q <= bus.count;
        end
        EXEC: begin
          res_ptr_q  <= ptr_q;
          res_data_q <= alu_res;
          res_err_q  <= alu_err;
          mod_q      <= (instr.opc == MOD);
        end
        DIVW: if (div_done) begin
          res_data_q <= mod_q ? div_rem : div_quo;
          res_err_q  <= 1'b0;
        end
        OUT: if (bus.res_ready) begin
          ptr_q       <= next_ptr;
          remaining_q <= remaining_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  instr_div_iter #(.DIV_BITS(DIV_BITS)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (instr.op_a),
    .divisor   (instr.op_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign bus.busy         = busy_o;
  assign bus.done         = done_o;
  assign bus.res_valid    = valid_o;
  assign bus.read_pointer = ptr_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_ptr      = res_ptr_q;
  assign bus.res_err      = res_err_q;

endmodule
